// File: rtl/axi_lite_master_interface_pkg.sv
// Shared AXI4-Lite definitions: response codes, cache/prot defaults, FSM encodings.
// Also holds the timeout limit used when AXI_LITE_MASTER_TIMEOUT_EN is defined.
package axi_lite_master_interface_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;

    localparam int          TIMEOUT_W     = 16;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_OUT  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/axi_lite_master_interface_timeout.sv
// Response-wait watchdog: down-counter reloaded while idle, flags expiry at terminal count.
// Only instantiated when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module axi_lite_master_interface_timeout
    import axi_lite_master_interface_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic count_en_i,
    output logic expired_o
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!count_en_i) begin
            cnt_d = TIMEOUT_LIMIT;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= TIMEOUT_LIMIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = count_en_i && (cnt_q == '0);

endmodule

// File: rtl/axi_lite_master_interface.sv
// AXI4-Lite initiator: independent write and read FSMs driven by a simple user request bus.
// Optional response timeout via AXI_LITE_MASTER_TIMEOUT_EN.
//   state  | meaning
//   W_IDLE | accepting a user write
//   W_REQ  | AW and W valid until each handshakes
//   W_RESP | BREADY high, waiting for B
//   R_IDLE | accepting a user read
//   R_ADDR | ARVALID high until ARREADY
//   R_DATA | RREADY high, waiting for R
//   R_OUT  | rd_dvalid high until rd_dready
module axi_lite_master_interface
    import axi_lite_master_interface_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET,

    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] wr_strb,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    output logic                            wr_done,
    output logic [1:0]                      wr_resp,

    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   rd_addr,
    input  logic                            rd_valid,
    output logic                            rd_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
    output logic [1:0]                      rd_resp,
    output logic                            rd_dvalid,
    input  logic                            rd_dready,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    wr_state_e         wr_state_q, wr_state_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              wr_done_q, wr_done_d;
    logic [1:0]        wr_resp_q, wr_resp_d;
    logic              wr_drain_q, wr_drain_d;

    rd_state_e         rd_state_q, rd_state_d;
    logic [AW-1:0]     araddr_q, araddr_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;
    logic [1:0]        rd_resp_q, rd_resp_d;
    logic              rd_drain_q, rd_drain_d;

    logic              aw_hs, w_hs;
    logic              wr_timeout, rd_timeout;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    axi_lite_master_interface_timeout u_wr_timeout (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .count_en_i (wr_state_q == W_RESP),
        .expired_o  (wr_timeout)
    );

    axi_lite_master_interface_timeout u_rd_timeout (
        .clk_i      (ACLK),
        .rst_i      (ARESET),
        .count_en_i (rd_state_q == R_DATA),
        .expired_o  (rd_timeout)
    );
`else
    assign wr_timeout = 1'b0;
    assign rd_timeout = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_resp_q  <= RESP_OKAY;
            wr_drain_q <= 1'b0;
            rd_state_q <= R_IDLE;
            araddr_q   <= '0;
            rd_data_q  <= '0;
            rd_resp_q  <= RESP_OKAY;
            rd_drain_q <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            wr_done_q  <= wr_done_d;
            wr_resp_q  <= wr_resp_d;
            wr_drain_q <= wr_drain_d;
            rd_state_q <= rd_state_d;
            araddr_q   <= araddr_d;
            rd_data_q  <= rd_data_d;
            rd_resp_q  <= rd_resp_d;
            rd_drain_q <= rd_drain_d;
        end
    end

    assign aw_hs = (wr_state_q == W_REQ) && !aw_done_q && M_AXI_AWREADY;
    assign w_hs  = (wr_state_q == W_REQ) && !w_done_q  && M_AXI_WREADY;

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        wr_done_d  = 1'b0;
        wr_resp_d  = wr_resp_q;
        wr_drain_d = wr_drain_q;
        // A late B from a timed-out write is swallowed wherever the FSM currently is.
        if (wr_drain_q && M_AXI_BVALID && (wr_state_q != W_RESP)) begin
            wr_drain_d = 1'b0;
        end
        case (wr_state_q)
            W_IDLE: begin
                if (wr_valid) begin
                    awaddr_d   = wr_addr;
                    wdata_d    = wr_data;
                    wstrb_d    = wr_strb;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (M_AXI_BVALID) begin
                    if (wr_drain_q) begin
                        wr_drain_d = 1'b0;
                    end else begin
                        wr_resp_d  = M_AXI_BRESP;
                        wr_done_d  = 1'b1;
                        wr_state_d = W_IDLE;
                    end
                end else if (wr_timeout) begin
                    wr_resp_d  = RESP_SLVERR;
                    wr_done_d  = 1'b1;
                    wr_drain_d = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        wr_ready      = (wr_state_q == W_IDLE);
        wr_done       = wr_done_q;
        wr_resp       = wr_resp_q;
        M_AXI_AWADDR  = awaddr_q;
        M_AXI_AWCACHE = CACHE_DEFAULT;
        M_AXI_AWPROT  = PROT_DEFAULT;
        M_AXI_AWVALID = (wr_state_q == W_REQ) && !aw_done_q;
        M_AXI_WDATA   = wdata_q;
        M_AXI_WSTRB   = wstrb_q;
        M_AXI_WVALID  = (wr_state_q == W_REQ) && !w_done_q;
        M_AXI_BREADY  = (wr_state_q == W_RESP) || wr_drain_q;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        rd_data_d  = rd_data_q;
        rd_resp_d  = rd_resp_q;
        rd_drain_d = rd_drain_q;
        if (rd_drain_q && M_AXI_RVALID && (rd_state_q != R_DATA)) begin
            rd_drain_d = 1'b0;
        end
        case (rd_state_q)
            R_IDLE: begin
                if (rd_valid) begin
                    araddr_d   = rd_addr;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (M_AXI_ARREADY) rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (M_AXI_RVALID) begin
                    if (rd_drain_q) begin
                        rd_drain_d = 1'b0;
                    end else begin
                        rd_data_d  = M_AXI_RDATA;
                        rd_resp_d  = M_AXI_RRESP;
                        rd_state_d = R_OUT;
                    end
                end else if (rd_timeout) begin
                    rd_data_d  = '0;
                    rd_resp_d  = RESP_SLVERR;
                    rd_drain_d = 1'b1;
                    rd_state_d = R_OUT;
                end
            end
            R_OUT: begin
                if (rd_dready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rd_ready      = (rd_state_q == R_IDLE);
        rd_data       = rd_data_q;
        rd_resp       = rd_resp_q;
        rd_dvalid     = (rd_state_q == R_OUT);
        M_AXI_ARADDR  = araddr_q;
        M_AXI_ARCACHE = CACHE_DEFAULT;
        M_AXI_ARPROT  = PROT_DEFAULT;
        M_AXI_ARVALID = (rd_state_q == R_ADDR);
        M_AXI_RREADY  = (rd_state_q == R_DATA) || rd_drain_q;
    end

endmodule

// File: tb/tb_axi_lite_master_interface.sv
// Directed self-checking bench for axi_lite_master_interface; the timeout scenario
// only runs when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master_interface;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready, wr_done, rd_valid, rd_ready, rd_dvalid, rd_dready;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awcache, arcache, wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_master_interface dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_done       (wr_done),
        .wr_resp       (wr_resp),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_resp       (rd_resp),
        .rd_dvalid     (rd_dvalid),
        .rd_dready     (rd_dready),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWCACHE (awcache),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARCACHE (arcache),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESET = 1'b1;
        wr_addr = '0; wr_data = '0; wr_strb = '0; wr_valid = 1'b0;
        rd_addr = '0; rd_valid = 1'b0; rd_dready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        repeat (3) tick();
        ARESET = 1'b0;

        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_ready", rd_ready, 1);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, wr_done, rd_dvalid}, 0);
        check("rst_resps", {wr_resp, rd_resp}, 0);
        check("rst_rd_data", rd_data, 0);
        check("cache_prot", {awcache, awprot, arcache, arprot}, {4'b0011, 3'b000, 4'b0011, 3'b000});

        // 1: min-latency write, slave always ready
        wr_addr = 32'h10; wr_data = 32'hDEADBEEF; wr_strb = 4'hF; wr_valid = 1'b1;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        tick();
        wr_valid = 1'b0;
        check("t1_aw_w_valid", {awvalid, wvalid, wr_ready}, 3'b110);
        check("t1_payload", {awaddr, wdata}, {32'h10, 32'hDEADBEEF});
        check("t1_wstrb", wstrb, 4'hF);
        tick();
        check("t1_bready", {bready, awvalid, wvalid, wr_done}, 4'b1000);
        tick();
        bvalid = 1'b0;
        check("t1_done", {wr_done, wr_resp, wr_ready, bready}, 5'b1_00_1_0);
        tick();
        check("t1_done_pulse", wr_done, 0);

        // 2: AWREADY late, WREADY immediate
        wr_addr = 32'h14; wr_data = 32'hA5A5A5A5; wr_strb = 4'h3; wr_valid = 1'b1;
        awready = 1'b0; wready = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("t2_both_valid", {awvalid, wvalid}, 2'b11);
        tick();
        check("t2_w_dropped", {awvalid, wvalid}, 2'b10);
        tick();
        check("t2_aw_held", {awvalid, awaddr}, {1'b1, 32'h14});
        tick();
        check("t2_aw_held2", {awvalid, bready}, 2'b10);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("t2_resp_phase", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1'b1; bresp = 2'b11;
        tick();
        bvalid = 1'b0;
        check("t2_done", {wr_done, wr_resp}, 3'b1_11);
        tick();
        check("t2_single_done", {wr_done, wr_ready}, 2'b01);

        // 3: read with error response and delayed consume
        rd_addr = 32'h20; rd_valid = 1'b1; arready = 1'b0;
        tick();
        rd_valid = 1'b0;
        check("t3_arvalid", {arvalid, araddr, rd_ready}, {1'b1, 32'h20, 1'b0});
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("t3_rready", {arvalid, rready}, 2'b01);
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rdata = 32'hFFFF0000; rresp = 2'b00;
        check("t3_capture", {rd_dvalid, rd_data, rd_resp, rready}, {1'b1, 32'h12345678, 2'b10, 1'b0});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_hold", {rd_dvalid, rd_data, rd_resp, rd_ready}, {1'b1, 32'h12345678, 2'b10, 1'b0});
        end
        rd_dready = 1'b1;
        tick();
        rd_dready = 1'b0;
        check("t3_consumed", {rd_dvalid, rd_ready}, 2'b01);

        // 4: concurrent write and read, R returns before B
        wr_addr = 32'h40; wr_data = 32'h0BADF00D; wr_strb = 4'h8; wr_valid = 1'b1;
        rd_addr = 32'h44; rd_valid = 1'b1;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        tick();
        wr_valid = 1'b0; rd_valid = 1'b0;
        check("t4_req", {awvalid, wvalid, arvalid, araddr}, {3'b111, 32'h44});
        tick();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        check("t4_wait", {bready, rready}, 2'b11);
        rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        check("t4_read_first", {rd_dvalid, rd_data, wr_done, bready}, {1'b1, 32'hCAFEF00D, 1'b0, 1'b1});
        bvalid = 1'b1; bresp = 2'b01; rd_dready = 1'b1;
        tick();
        bvalid = 1'b0; rd_dready = 1'b0;
        check("t4_write_done", {wr_done, wr_resp, rd_dvalid, rd_ready}, 5'b1_01_0_1);

        // 5: reset mid-write
        wr_addr = 32'h30; wr_data = 32'h1; wr_strb = 4'h1; wr_valid = 1'b1;
        awready = 1'b0; wready = 1'b0;
        tick();
        wr_valid = 1'b0;
        check("t5_pre", awvalid, 1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check("t5_abandon", {awvalid, wvalid, bready, arvalid, rready, wr_ready, wr_done}, 7'b0000010);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        repeat (2) begin
            tick();
            check("t5_no_done", {wr_done, awvalid, wvalid}, 3'b000);
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // 6: B never arrives, watchdog forces SLVERR, late B drained
        begin
            int waited;
            wr_addr = 32'h50; wr_data = 32'h5; wr_strb = 4'hF; wr_valid = 1'b1;
            awready = 1'b1; wready = 1'b1;
            tick();
            wr_valid = 1'b0;
            tick();
            awready = 1'b0; wready = 1'b0;
            check("t6_resp_phase", bready, 1);
            waited = 0;
            while (!wr_done && waited < 70000) begin
                tick();
                waited++;
            end
            check("t6_timeout_cycles", waited, 32'h10000);
            check("t6_slverr", {wr_done, wr_resp, wr_ready, bready}, 5'b1_10_1_1);
            bvalid = 1'b1; bresp = 2'b00;
            tick();
            bvalid = 1'b0;
            check("t6_drained", {wr_done, wr_resp, bready}, 4'b0_10_0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
